// File: rtl/mips_pkg.sv
// Shared definitions for the BrPred MIPS fetch stage: opcodes, the nop encoding,
// the branch-history counter reset value and small helper functions.
package mips_pkg;

  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [1:0]  BHT_INIT = 2'b01;

  // True when the opcode is one of the two conditional branches we predict.
  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Two-bit saturating counter step: taken counts up to 11, not-taken down to 00.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/if_stage_bpred_if.sv
// Bundle of the fetch stage's hazard-unit controls, I-cache port, branch
// resolution inputs from ID and the IF/ID register outputs.
interface if_stage_bpred_if #(
  parameter int PC_W = 32
);

  logic            PCWrite;
  logic            if_id_Write;
  logic            ICACHE_stall;
  logic [31:0]     ICACHE_rdata;
  logic [PC_W-1:0] ICACHE_addr;
  logic            br_valid_ID;
  logic            br_taken_ID;
  logic [PC_W-1:0] br_target_ID;
  logic [PC_W-1:0] if_id_pc4;
  logic [31:0]     if_id_instr;
  logic            if_id_pred;

  // The fetch stage itself.
  modport master (
    input  PCWrite, if_id_Write, ICACHE_stall, ICACHE_rdata,
    input  br_valid_ID, br_taken_ID, br_target_ID,
    output ICACHE_addr, if_id_pc4, if_id_instr, if_id_pred
  );

  // The surrounding pipeline / cache driving the stage.
  modport slave (
    output PCWrite, if_id_Write, ICACHE_stall, ICACHE_rdata,
    output br_valid_ID, br_taken_ID, br_target_ID,
    input  ICACHE_addr, if_id_pc4, if_id_instr, if_id_pred
  );

endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters. Combinational read,
// single synchronous write. A read and write of the same entry on one edge
// returns the old value (no bypass).
module bht_2bit
  import mips_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx_r,
  output logic             pred_r,
  input  logic             we,
  input  logic [IDX_W-1:0] idx_w,
  input  logic             taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] r_cnt [DEPTH];

  // Counter array: all entries weakly not-taken on reset, one entry trained per resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= BHT_INIT;
      end
    end else if (we) begin
      r_cnt[idx_w] <= sat_update(r_cnt[idx_w], taken);
    end
  end

  assign pred_r = r_cnt[idx_r][1];

endmodule

// File: rtl/if_stage_bpred.sv
// Instruction fetch stage: PC register, BHT-based prediction of beq/bne,
// static branch target adder and the IF/ID pipeline register.
module if_stage_bpred
  import mips_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  if_stage_bpred_if.master bus
);

  localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_if_id_pc4;
  logic [31:0]     r_if_id_instr;
  logic            r_if_id_pred;

  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_pc4_nxt;
  logic [31:0]      w_instr_nxt;
  logic             w_pred_nxt;

  logic [PC_W-1:0]  w_pc4;
  logic [PC_W-1:0]  w_imm_off;
  logic [PC_W-1:0]  w_tgt;
  logic [PC_W-1:0]  w_next_seq;
  logic             w_is_br;
  logic             w_bht_pred;
  logic             w_pred;
  logic [IDX_W-1:0] w_idx_if;
  logic [IDX_W-1:0] w_idx_id;
  logic             w_resolve;
  logic             w_mispred;

  // Prediction datapath for the instruction currently being fetched.
  assign w_pc4      = r_pc + PC_STEP;
  assign w_imm_off  = {{(PC_W-18){bus.ICACHE_rdata[15]}}, bus.ICACHE_rdata[15:0], 2'b00};
  assign w_tgt      = w_pc4 + w_imm_off;
  assign w_is_br    = is_branch(bus.ICACHE_rdata[31:26]);
  assign w_idx_if   = r_pc[IDX_W+1:2];
  assign w_pred     = w_is_br & w_bht_pred;
  assign w_next_seq = w_pred ? w_tgt : w_pc4;

  // The ID instruction sits at pc4-4; subtracting 4 never disturbs bits [1:0],
  // so the index is simply the pc4 index field minus one.
  assign w_idx_id  = r_if_id_pc4[IDX_W+1:2] - IDX_ONE;
  assign w_resolve = bus.br_valid_ID & bus.if_id_Write & ~bus.ICACHE_stall;
  assign w_mispred = w_resolve & (bus.br_taken_ID != r_if_id_pred);

  bht_2bit #(
    .IDX_W (IDX_W)
  ) u_bht (
    .clk    (clk),
    .rst_n  (rst_n),
    .idx_r  (w_idx_if),
    .pred_r (w_bht_pred),
    .we     (w_resolve),
    .idx_w  (w_idx_id),
    .taken  (bus.br_taken_ID)
  );

  // Next PC and IF/ID contents: stall freezes, mispredict redirects and flushes,
  // otherwise PCWrite / if_id_Write gate the normal advance.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_pc4_nxt   = r_if_id_pc4;
    w_instr_nxt = r_if_id_instr;
    w_pred_nxt  = r_if_id_pred;
    if (bus.ICACHE_stall) begin
      w_pc_nxt = r_pc;
    end else if (w_mispred) begin
      w_pc_nxt    = bus.br_taken_ID ? bus.br_target_ID : r_if_id_pc4;
      w_instr_nxt = NOP;
      w_pred_nxt  = 1'b0;
    end else begin
      if (bus.PCWrite) begin
        w_pc_nxt = w_next_seq;
      end else begin
        w_pc_nxt = r_pc;
      end
      if (bus.if_id_Write) begin
        w_pc4_nxt   = w_pc4;
        w_instr_nxt = bus.ICACHE_rdata;
        w_pred_nxt  = w_pred;
      end else begin
        w_pc4_nxt = r_if_id_pc4;
      end
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_if_id_pc4   <= '0;
      r_if_id_instr <= NOP;
      r_if_id_pred  <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_if_id_pc4   <= w_pc4_nxt;
      r_if_id_instr <= w_instr_nxt;
      r_if_id_pred  <= w_pred_nxt;
    end
  end

  assign bus.ICACHE_addr = r_pc;
  assign bus.if_id_pc4   = r_if_id_pc4;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_pred  = r_if_id_pred;

endmodule

// File: tb/tb_if_stage_bpred.sv
// Scoreboard bench for if_stage_bpred: directed scenarios then random traffic,
// each cycle's expected state comes from a behavioural model of the fetch rules.
module tb_if_stage_bpred;

  logic clk;
  logic rst_n;

  if_stage_bpred_if #(.PC_W(32)) bus ();

  if_stage_bpred #(.IDX_W(6), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        pred;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit [31:0] m_pc;
  bit [31:0] m_pc4;
  bit [31:0] m_instr;
  bit        m_pred;
  int        m_bht [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_state();
    exp_t e;
    e.addr  = m_pc;
    e.pc4   = m_pc4;
    e.instr = m_instr;
    e.pred  = m_pred;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = 0; m_pc4 = 0; m_instr = 0; m_pred = 0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic idle_inputs();
    bus.PCWrite = 1'b1; bus.if_id_Write = 1'b1; bus.ICACHE_stall = 1'b0;
    bus.ICACHE_rdata = 32'h0; bus.br_valid_ID = 1'b0; bus.br_taken_ID = 1'b0;
    bus.br_target_ID = 32'h0;
  endtask

  // Hold reset across one rising edge; outputs must already show reset values.
  task automatic reset_pulse();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    push_state();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; the model computes what the stage must hold after the edge.
  task automatic step(input bit st, input bit pcw, input bit ifw, input bit bv,
                      input bit bt, input bit [31:0] btgt, input bit [31:0] rdata);
    bit [31:0] pc4, tgt, old_pc4;
    bit        isbr, pred, res, mis;
    int        idx, idid, off;
    bus.ICACHE_stall = st; bus.PCWrite = pcw; bus.if_id_Write = ifw;
    bus.br_valid_ID = bv; bus.br_taken_ID = bt; bus.br_target_ID = btgt;
    bus.ICACHE_rdata = rdata;

    pc4  = m_pc + 32'd4;
    isbr = (rdata[31:26] == 6'h04) || (rdata[31:26] == 6'h05);
    idx  = int'((m_pc / 4) % 64);
    pred = isbr && (m_bht[idx] >= 2);
    off  = int'($signed(rdata[15:0])) * 4;
    tgt  = pc4 + 32'(off);
    res  = bv && ifw && !st;
    mis  = res && (bt != m_pred);
    old_pc4 = m_pc4;
    if (!st) begin
      if (res) begin
        idid = int'(((old_pc4 - 32'd4) / 4) % 64);
        if (bt) m_bht[idid] = (m_bht[idid] == 3) ? 3 : m_bht[idid] + 1;
        else    m_bht[idid] = (m_bht[idid] == 0) ? 0 : m_bht[idid] - 1;
      end
      if (mis) begin
        m_pc    = bt ? btgt : old_pc4;
        m_instr = 0;
        m_pred  = 0;
      end else begin
        if (pcw) m_pc = pred ? tgt : pc4;
        if (ifw) begin
          m_pc4 = pc4; m_instr = rdata; m_pred = pred;
        end
      end
    end
    push_state();
    @(posedge clk);
    #3;
  endtask

  function automatic bit [31:0] br_word(input bit bne, input bit [15:0] imm);
    return {(bne ? 6'h05 : 6'h04), 5'd1, 5'd2, imm};
  endfunction

  // Monitor: after every edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ICACHE_addr", bus.ICACHE_addr, e.addr);
        chk("if_id_pc4",   bus.if_id_pc4,   e.pc4);
        chk("if_id_instr", bus.if_id_instr, e.instr);
        chk("if_id_pred",  {31'd0, bus.if_id_pred}, {31'd0, e.pred});
      end
    end
  end

  initial begin
    bit [31:0] rd, tg;
    int        r;
    rst_n = 1'b0;
    idle_inputs();
    reset_pulse();

    // Free run over nops: 0,4,8,C then PC=0x10
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 32'h0, 32'h0);
    // beq at 0x10, imm 3, counter 01 -> not predicted
    step(0, 1, 1, 0, 0, 32'h0, br_word(0, 16'h0003));
    // resolve taken to 0x20 -> flush and redirect
    step(0, 1, 1, 1, 1, 32'h20, 32'h0);
    // force refetch of 0x10 (resolution against flushed slot trains the same entry)
    step(0, 1, 1, 1, 1, 32'h10, 32'h0);
    // refetch beq: now predicted taken to 0x20
    step(0, 1, 1, 0, 0, 32'h0, br_word(0, 16'h0003));
    // correct taken resolution, then one not-taken (mispredict, counter drops)
    step(0, 1, 1, 1, 1, 32'h20, 32'h0);
    step(0, 1, 1, 1, 1, 32'h10, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0, br_word(1, 16'h0003));
    step(0, 1, 1, 1, 0, 32'h0, 32'h0);
    // full hazard hold with br_valid high: nothing moves, no training
    step(0, 1, 1, 1, 1, 32'h10, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0, br_word(0, 16'h0003));
    step(0, 0, 0, 1, 0, 32'h0, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0, 32'h0);
    // stall coincident with mispredict, then release
    step(1, 1, 1, 1, 0, 32'h0, 32'h0);
    step(1, 1, 1, 1, 0, 32'h0, 32'h0);
    step(0, 1, 1, 1, 0, 32'h0, 32'h0);
    // PCWrite=0 with if_id_Write=1 re-latches the same fetch
    step(0, 0, 1, 0, 0, 32'h0, 32'h1234_5678);
    // wrap the PC past the top of the address space
    step(0, 1, 1, 1, 1, 32'hFFFF_FFF8, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'h0, 32'h0);
    // mid-stream reset discards training
    reset_pulse();
    step(0, 1, 1, 0, 0, 32'h0, 32'h0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 4)       rd = br_word(r[0], 16'($signed($urandom_range(0, 16)) - 8));
        else if (r == 4) rd = $urandom;
        else             rd = 32'h0;
        tg = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 63) * 4);
        step($urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0,
             $urandom_range(0, 19) != 0, $urandom_range(0, 9) < 4,
             $urandom_range(0, 1) == 1, tg, rd);
      end
    end

    // Drain: every expectation must have been consumed by the monitor
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
